// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller: stretches a one-cycle load/store into a timed SRAM handshake and freezes the pipeline meanwhile.
// Optional UART memory-mapped I/O at 0xBF00/0xBF01 is enabled by defining MEM_UART_MMIO_EN.
module mem_access_unit #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [15:0] address,
  input  logic [15:0] writeData,
  output logic [15:0] dataOut,
  output logic        freeze,
  output logic [15:0] ramAddr,
  output logic [15:0] ramDataOut,
  output logic        ramDataOe,
  input  logic [15:0] ramDataIn,
`ifdef MEM_UART_MMIO_EN
  output logic        uartRdn,
  output logic        uartWrn,
  input  logic        uartDataReady,
  input  logic        uartTbre,
  input  logic        uartTsre,
`endif
  output logic        ramCE_n,
  output logic        ramOE_n,
  output logic        ramWE_n
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] addr_q;
  logic [15:0] dataOut_q;
  logic [15:0] ramDataOut_q;
  logic        ramDataOe_q;
  logic        ramCE_n_q, ramOE_n_q, ramWE_n_q;

  logic        storeGo, loadGo, statRead, uartSel, reqStall;
  logic [15:0] statusWord;

`ifdef MEM_UART_MMIO_EN
  logic uartRdn_q, uartWrn_q;
  logic isUartData, isUartStat;

  // The status register answers in the IDLE cycle itself, so it never stalls
  assign isUartData = (address == 16'hBF00);
  assign isUartStat = (address == 16'hBF01);
  assign storeGo    = memWrite && !isUartStat;
  assign loadGo     = !memWrite && memRead && !isUartStat;
  assign statRead   = !memWrite && memRead && isUartStat;
  assign uartSel    = isUartData;
  assign reqStall   = (memRead || memWrite) && !isUartStat;
  assign statusWord = {14'b0, uartDataReady, uartTbre & uartTsre};
  assign uartRdn    = uartRdn_q;
  assign uartWrn    = uartWrn_q;
`else
  assign storeGo    = memWrite;
  assign loadGo     = !memWrite && memRead;
  assign statRead   = 1'b0;
  assign uartSel    = 1'b0;
  assign reqStall   = memRead || memWrite;
  assign statusWord = 16'h0000;
`endif

  assign freeze     = !RST && ((state_q == IDLE && reqStall) || state_q == READ || state_q == WRITE);
  assign ramAddr    = (state_q == IDLE) ? address : addr_q;
  assign dataOut    = dataOut_q;
  assign ramDataOut = ramDataOut_q;
  assign ramDataOe  = ramDataOe_q;
  assign ramCE_n    = ramCE_n_q;
  assign ramOE_n    = ramOE_n_q;
  assign ramWE_n    = ramWE_n_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      dataOut_q    <= '0;
      ramDataOut_q <= '0;
      ramDataOe_q  <= 1'b0;
      ramCE_n_q    <= 1'b1;
      ramOE_n_q    <= 1'b1;
      ramWE_n_q    <= 1'b1;
`ifdef MEM_UART_MMIO_EN
      uartRdn_q    <= 1'b1;
      uartWrn_q    <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (storeGo) begin
            addr_q       <= address;
            ramDataOut_q <= writeData;
            ramDataOe_q  <= 1'b1;
            state_q      <= WRITE;
            if (uartSel) begin
`ifdef MEM_UART_MMIO_EN
              uartWrn_q <= 1'b0;
`endif
            end else begin
              ramCE_n_q <= 1'b0;
              ramWE_n_q <= 1'b0;
            end
          end else if (loadGo) begin
            addr_q  <= address;
            state_q <= READ;
            if (uartSel) begin
`ifdef MEM_UART_MMIO_EN
              uartRdn_q <= 1'b0;
`endif
            end else begin
              ramCE_n_q <= 1'b0;
              ramOE_n_q <= 1'b0;
            end
          end else if (statRead) begin
            dataOut_q <= statusWord;
          end
        end
        READ, WRITE: begin
          // Strobes rise on the same edge that enters DONE; bus drive lingers one more cycle for stores
          if (cnt_q == LAST) begin
            if (state_q == READ) dataOut_q <= ramDataIn;
            ramCE_n_q <= 1'b1;
            ramOE_n_q <= 1'b1;
            ramWE_n_q <= 1'b1;
`ifdef MEM_UART_MMIO_EN
            uartRdn_q <= 1'b1;
            uartWrn_q <= 1'b1;
`endif
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          ramDataOe_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: two instances (WAIT_CYCLES 1 and 2) with a per-cycle expected-output scoreboard.
// Builds with or without MEM_UART_MMIO_EN.
module tb_mem_access_unit;

  localparam int WC0 = 1;
  localparam int WC1 = 2;

  typedef struct packed {
    logic        freeze;
    logic        ce;
    logic        oe;
    logic        we;
    logic        doe;
    logic        rdn;
    logic        wrn;
    logic [15:0] ramAddr;
    logic [15:0] ramDataOut;
    logic [15:0] dataOut;
  } out_t;

  typedef enum logic [1:0] {PH_IDLE, PH_REQ, PH_ACT, PH_DONE} ph_t;

  typedef struct {
    bit          rdReq;
    bit          wrReq;
    logic [15:0] a;
    logic [15:0] wd;
    logic [15:0] rdata;
  } txn_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        memRead, memWrite;
  logic [15:0] address, writeData, ramDataIn;
  logic        uartDataReady, uartTbre, uartTsre;
  int          sel;

  logic        rd0, wr0, rd1, wr1;
  logic [15:0] dataOut0, ramAddr0, rdo0, dataOut1, ramAddr1, rdo1;
  logic        freeze0, doe0, ce0, oe0, we0, rdn0, wrn0;
  logic        freeze1, doe1, ce1, oe1, we1, rdn1, wrn1;

  out_t        obs;
  out_t        expQ[$];
  logic [15:0] expData[2];
  logic [15:0] expRdo[2];
  int          checks = 0;
  int          errors = 0;

  always #5 CLK = ~CLK;

  // Only the selected instance sees requests; the other sits idle
  assign rd0 = (sel == 0) && memRead;
  assign wr0 = (sel == 0) && memWrite;
  assign rd1 = (sel == 1) && memRead;
  assign wr1 = (sel == 1) && memWrite;

  mem_access_unit #(.WAIT_CYCLES(WC0)) dut0 (
    .CLK(CLK), .RST(RST), .memRead(rd0), .memWrite(wr0), .address(address), .writeData(writeData),
    .dataOut(dataOut0), .freeze(freeze0), .ramAddr(ramAddr0), .ramDataOut(rdo0), .ramDataOe(doe0),
    .ramDataIn(ramDataIn),
`ifdef MEM_UART_MMIO_EN
    .uartRdn(rdn0), .uartWrn(wrn0), .uartDataReady(uartDataReady), .uartTbre(uartTbre), .uartTsre(uartTsre),
`endif
    .ramCE_n(ce0), .ramOE_n(oe0), .ramWE_n(we0)
  );

  mem_access_unit #(.WAIT_CYCLES(WC1)) dut1 (
    .CLK(CLK), .RST(RST), .memRead(rd1), .memWrite(wr1), .address(address), .writeData(writeData),
    .dataOut(dataOut1), .freeze(freeze1), .ramAddr(ramAddr1), .ramDataOut(rdo1), .ramDataOe(doe1),
    .ramDataIn(ramDataIn),
`ifdef MEM_UART_MMIO_EN
    .uartRdn(rdn1), .uartWrn(wrn1), .uartDataReady(uartDataReady), .uartTbre(uartTbre), .uartTsre(uartTsre),
`endif
    .ramCE_n(ce1), .ramOE_n(oe1), .ramWE_n(we1)
  );

`ifndef MEM_UART_MMIO_EN
  assign rdn0 = 1'b1;
  assign wrn0 = 1'b1;
  assign rdn1 = 1'b1;
  assign wrn1 = 1'b1;
`endif

  always_comb begin
    obs = '0;
    if (sel == 0) begin
      obs = '{freeze0, ce0, oe0, we0, doe0, rdn0, wrn0, ramAddr0, rdo0, dataOut0};
    end else begin
      obs = '{freeze1, ce1, oe1, we1, doe1, rdn1, wrn1, ramAddr1, rdo1, dataOut1};
    end
  end

  // Reference model of the outputs for one cycle of a transaction phase
  function automatic out_t model(int k, ph_t p, bit wr, bit uart, logic [15:0] a, logic [15:0] curAddr);
    out_t e;
    bit   act;
    act          = (p == PH_ACT);
    e.freeze     = (p == PH_REQ) || act;
    e.ce         = !(act && !uart);
    e.oe         = !(act && !wr && !uart);
    e.we         = !(act && wr && !uart);
    e.rdn        = !(act && !wr && uart);
    e.wrn        = !(act && wr && uart);
    e.doe        = wr && (act || p == PH_DONE);
    e.ramAddr    = (act || p == PH_DONE) ? a : curAddr;
    e.ramDataOut = expRdo[k];
    e.dataOut    = expData[k];
    return e;
  endfunction

  task automatic test_reset();
    out_t got, exp;
    memRead = 1'b1; memWrite = 1'b0; address = 16'h0033; writeData = 16'h0000; ramDataIn = 16'h0000;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    for (int k = 0; k < 2; k++) begin
      expData[k] = 16'h0000;
      expRdo[k]  = 16'h0000;
      sel = k;
      #1;
      expQ.push_back(model(k, PH_IDLE, 0, 0, 16'h0000, address));
      got = obs; exp = expQ.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL reset_values dut%0d: got %h expected %h", k, got, exp); end
    end
    sel = 0;
    @(negedge CLK); RST = 1'b0; #1;
    expQ.push_back(model(0, PH_REQ, 0, 0, 16'h0033, address));
    got = obs; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL reset_req: got %h expected %h", got, exp); end
    @(posedge CLK); #1;
    expQ.push_back(model(0, PH_ACT, 0, 0, 16'h0033, address));
    got = obs; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL reset_read_active: got %h expected %h", got, exp); end
    #1 RST = 1'b1;
    #1;
    expQ.push_back(model(0, PH_IDLE, 0, 0, 16'h0000, address));
    got = obs; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL reset_midread_async: got %h expected %h", got, exp); end
    memRead = 1'b0;
    @(negedge CLK); RST = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge CLK); #1;
      expQ.push_back(model(0, PH_IDLE, 0, 0, 16'h0000, address));
      got = obs; exp = expQ.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL reset_no_retry c%0d: got %h expected %h", c, got, exp); end
    end
  endtask

  task automatic test_load();
    out_t got, exp;
    ph_t  ph;
    int   fCnt = 0, oCnt = 0;
    sel = 1; memRead = 1'b1; memWrite = 1'b0; address = 16'h0040; ramDataIn = 16'h1234;
    for (int c = 0; c <= WC1 + 1; c++) begin
      ph = (c == 0) ? PH_REQ : (c <= WC1) ? PH_ACT : PH_DONE;
      if (ph == PH_DONE) expData[1] = 16'h1234;
      expQ.push_back(model(1, ph, 0, 0, 16'h0040, address));
      @(negedge CLK);
      got = obs;
      if (got.freeze) fCnt++;
      if (!got.oe) oCnt++;
      exp = expQ.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL load c%0d: got %h expected %h", c, got, exp); end
      @(posedge CLK); #1;
    end
    memRead = 1'b0; ramDataIn = 16'h0BAD;
    expQ.push_back(model(1, PH_IDLE, 0, 0, 16'h0000, address));
    @(negedge CLK);
    got = obs; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL load_idle_hold: got %h expected %h", got, exp); end
    checks++;
    if (fCnt !== WC1 + 1) begin errors++; $display("[TB] FAIL load_freeze_cycles: got %0d expected %0d", fCnt, WC1 + 1); end
    checks++;
    if (oCnt !== WC1) begin errors++; $display("[TB] FAIL load_oe_cycles: got %0d expected %0d", oCnt, WC1); end
    @(posedge CLK); #1;
  endtask

  task automatic test_store();
    out_t got, exp;
    ph_t  ph;
    txn_t tx[2];
    int   weCnt = 0;
    tx[0] = '{1'b1, 1'b0, 16'h0007, 16'h0000, 16'h5A5A};
    tx[1] = '{1'b0, 1'b1, 16'h0100, 16'hABCD, 16'hFFFF};
    sel = 0;
    for (int t = 0; t < 2; t++) begin
      memRead = tx[t].rdReq; memWrite = tx[t].wrReq; address = tx[t].a;
      writeData = tx[t].wd; ramDataIn = tx[t].rdata;
      for (int c = 0; c <= WC0 + 1; c++) begin
        ph = (c == 0) ? PH_REQ : (c <= WC0) ? PH_ACT : PH_DONE;
        if (ph == PH_ACT && tx[t].wrReq) expRdo[0] = tx[t].wd;
        if (ph == PH_DONE && !tx[t].wrReq) expData[0] = tx[t].rdata;
        expQ.push_back(model(0, ph, tx[t].wrReq, 0, tx[t].a, address));
        @(negedge CLK);
        got = obs;
        if (!got.we) weCnt++;
        exp = expQ.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL store t%0d c%0d: got %h expected %h", t, c, got, exp); end
        @(posedge CLK); #1;
      end
      memRead = 1'b0; memWrite = 1'b0;
      expQ.push_back(model(0, PH_IDLE, tx[t].wrReq, 0, 16'h0000, address));
      @(negedge CLK);
      got = obs; exp = expQ.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL store_idle t%0d: got %h expected %h", t, got, exp); end
      @(posedge CLK); #1;
    end
    checks++;
    if (weCnt !== WC0) begin errors++; $display("[TB] FAIL store_we_cycles: got %0d expected %0d", weCnt, WC0); end
  endtask

  task automatic test_back_to_back();
    out_t got, exp;
    ph_t  ph;
    txn_t tx[2];
    tx[0] = '{1'b1, 1'b1, 16'h0010, 16'h7777, 16'h9999};
    tx[1] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'h4321};
    sel = 0;
    for (int t = 0; t < 2; t++) begin
      memRead = tx[t].rdReq; memWrite = tx[t].wrReq; address = tx[t].a;
      writeData = tx[t].wd; ramDataIn = tx[t].rdata;
      for (int c = 0; c <= WC0 + 1; c++) begin
        ph = (c == 0) ? PH_REQ : (c <= WC0) ? PH_ACT : PH_DONE;
        if (ph == PH_ACT && tx[t].wrReq) expRdo[0] = tx[t].wd;
        if (ph == PH_DONE && !tx[t].wrReq) expData[0] = tx[t].rdata;
        expQ.push_back(model(0, ph, tx[t].wrReq, 0, tx[t].a, address));
        @(negedge CLK);
        got = obs; exp = expQ.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL b2b t%0d c%0d: got %h expected %h", t, c, got, exp); end
        @(posedge CLK); #1;
      end
    end
    memRead = 1'b0; memWrite = 1'b0;
    expQ.push_back(model(0, PH_IDLE, 0, 0, 16'h0000, address));
    @(negedge CLK);
    got = obs; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL b2b_idle: got %h expected %h", got, exp); end
    @(posedge CLK); #1;
  endtask

`ifdef MEM_UART_MMIO_EN
  task automatic test_mmio();
    out_t got, exp;
    ph_t  ph;
    int   wrnCnt = 0, ceCnt = 0;
    sel = 0; uartDataReady = 1'b1; uartTbre = 1'b1; uartTsre = 1'b0;
    memRead = 1'b1; memWrite = 1'b0; address = 16'hBF01; ramDataIn = 16'hEEEE;
    expQ.push_back(model(0, PH_IDLE, 0, 0, 16'h0000, address));
    @(negedge CLK);
    got = obs; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL mmio_status_nofreeze: got %h expected %h", got, exp); end
    @(posedge CLK); #1;
    memRead = 1'b0; expData[0] = 16'h0002;
    expQ.push_back(model(0, PH_IDLE, 0, 0, 16'h0000, address));
    @(negedge CLK);
    got = obs; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL mmio_status_data: got %h expected %h", got, exp); end
    @(posedge CLK); #1;
    memWrite = 1'b1; address = 16'hBF00; writeData = 16'h0041;
    for (int c = 0; c <= WC0 + 1; c++) begin
      ph = (c == 0) ? PH_REQ : (c <= WC0) ? PH_ACT : PH_DONE;
      if (ph == PH_ACT) expRdo[0] = 16'h0041;
      expQ.push_back(model(0, ph, 1, 1, 16'hBF00, address));
      @(negedge CLK);
      got = obs;
      if (!got.wrn) wrnCnt++;
      if (!got.ce) ceCnt++;
      exp = expQ.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL mmio_uart_store c%0d: got %h expected %h", c, got, exp); end
      @(posedge CLK); #1;
    end
    checks++;
    if (wrnCnt !== WC0 || ceCnt !== 0) begin
      errors++; $display("[TB] FAIL mmio_wrn_cycles: got wrn=%0d ce=%0d expected wrn=%0d ce=0", wrnCnt, ceCnt, WC0);
    end
    address = 16'hBF01; writeData = 16'h5555;
    for (int c = 0; c < 2; c++) begin
      expQ.push_back(model(0, PH_IDLE, 0, 0, 16'h0000, address));
      @(negedge CLK);
      got = obs; exp = expQ.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL mmio_status_store_discard c%0d: got %h expected %h", c, got, exp); end
      @(posedge CLK); #1;
      memWrite = 1'b0;
    end
  endtask
`else
  task automatic test_plain_bf00();
    out_t got, exp;
    ph_t  ph;
    sel = 1; memRead = 1'b1; memWrite = 1'b0; address = 16'hBF00; ramDataIn = 16'h0BF0;
    for (int c = 0; c <= WC1 + 1; c++) begin
      ph = (c == 0) ? PH_REQ : (c <= WC1) ? PH_ACT : PH_DONE;
      if (ph == PH_DONE) expData[1] = 16'h0BF0;
      expQ.push_back(model(1, ph, 0, 0, 16'hBF00, address));
      @(negedge CLK);
      got = obs; exp = expQ.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL plain_bf00 c%0d: got %h expected %h", c, got, exp); end
      @(posedge CLK); #1;
    end
    memRead = 1'b0;
    @(posedge CLK); #1;
  endtask
`endif

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sel = 0;
    uartDataReady = 1'b0; uartTbre = 1'b0; uartTsre = 1'b0;
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
`ifdef MEM_UART_MMIO_EN
    test_mmio();
`else
    test_plain_bf00();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
